// File: rtl/ask_frame_sync_pkg.sv
// rtl/ask_frame_sync_pkg.sv - shared types and constants for the ASK frame synchroniser
// Purpose: FSM state encoding, default sync word and byte width used by the
//          interface, the bit deserialiser and the top level.
// Ports:   none (package)
package ask_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } ask_state_e;

  localparam logic [7:0] ASK_SYNC_WORD = 8'hA5;
  localparam int         ASK_BYTE_W    = 8;

endpackage

// File: rtl/ask_frame_sync_if.sv
// rtl/ask_frame_sync_if.sv - bit-stream input and frame/byte status bundle
// Purpose: groups the demodulator-side inputs and all framer outputs.
// Ports (signals):
//   en, bit_in, bit_valid                     driven by the master (bit source)
//   byte_out[7:0], byte_valid, frame_start,
//   frame_done, frame_ok, sync_lock,
//   frame_cnt[7:0], err_cnt[7:0]             driven by the slave (ask_frame_sync)
interface ask_frame_sync_if;
  import ask_pkg::*;

  logic                  en;
  logic                  bit_in;
  logic                  bit_valid;
  logic [ASK_BYTE_W-1:0] byte_out;
  logic                  byte_valid;
  logic                  frame_start;
  logic                  frame_done;
  logic                  frame_ok;
  logic                  sync_lock;
  logic [7:0]            frame_cnt;
  logic [7:0]            err_cnt;

  modport master (
    output en, bit_in, bit_valid,
    input  byte_out, byte_valid, frame_start, frame_done, frame_ok,
           sync_lock, frame_cnt, err_cnt
  );

  modport slave (
    input  en, bit_in, bit_valid,
    output byte_out, byte_valid, frame_start, frame_done, frame_ok,
           sync_lock, frame_cnt, err_cnt
  );

endinterface

// File: rtl/ask_frame_sync_deser.sv
// rtl/ask_frame_sync_deser.sv - MSB-first 8-bit deserialiser with bit counter
// Purpose: collects 8 bits into a byte; shared by payload and checksum reception.
// Ports:
//   clk, rst       clock, async active-high reset
//   clr            synchronous clear of shifter and counter (sync detect / abort)
//   shift, bit_in  accept one bit this cycle
//   byte_next[7:0] byte including the bit currently being shifted in
//   byte_done      high in the cycle the 8th bit is shifted (byte_next complete)
module ask_bit_deser
  import ask_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  shift,
  input  logic                  bit_in,
  output logic [ASK_BYTE_W-1:0] byte_next,
  output logic                  byte_done
);

  logic [ASK_BYTE_W-1:0] sr_q;
  logic [2:0]            cnt_q;

  assign byte_next = {sr_q[ASK_BYTE_W-2:0], bit_in};
  // clr and shift are never asserted together by the top level, so byte_done
  // need not depend on clr (keeps the top-level clear logic loop-free).
  assign byte_done = shift && (cnt_q == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (shift) begin
      sr_q  <= byte_next;
      cnt_q <= cnt_q + 3'd1;
    end
  end

endmodule

// File: rtl/ask_frame_sync.sv
// rtl/ask_frame_sync.sv - sync-word hunter, payload deserialiser and XOR checksum checker
// Purpose: hunts SYNC_WORD in the demodulated bit stream, emits PAYLOAD_LEN bytes,
//          verifies the trailing XOR checksum and keeps good/bad frame counters.
// Ports:
//   clk, rst    clock, async active-high reset
//   bus (slave) en, bit_in, bit_valid in; byte_out, byte_valid, frame_start,
//               frame_done, frame_ok, sync_lock, frame_cnt, err_cnt out (all registered)
module ask_frame_sync
  import ask_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD   = ASK_SYNC_WORD,
  parameter int         PAYLOAD_LEN = 4,
  parameter int         TIMEOUT_CYC = 65536
) (
  input  logic              clk,
  input  logic              rst,
  ask_frame_sync_if.slave   bus
);

  localparam int IDX_W = $clog2(PAYLOAD_LEN + 1);
  localparam int TIM_W = $clog2(TIMEOUT_CYC);

  ask_state_e            state_q, state_d;
  logic [7:0]            hunt_sr_q, hunt_sr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ASK_BYTE_W-1:0] ck_q, ck_d;
  logic [TIM_W-1:0]      timer_q, timer_d;
  logic [ASK_BYTE_W-1:0] byte_out_q, byte_out_d;
  logic                  byte_valid_q, byte_valid_d;
  logic                  frame_start_q, frame_start_d;
  logic                  frame_done_q, frame_done_d;
  logic                  frame_ok_q, frame_ok_d;
  logic                  sync_lock_q, sync_lock_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic                  acc;
  logic                  deser_clr;
  logic                  deser_shift;
  logic [ASK_BYTE_W-1:0] byte_next;
  logic                  byte_done;
  logic [7:0]            sync_cand;

  assign acc         = bus.en && bus.bit_valid;
  assign deser_shift = acc && (state_q != HUNT);
  assign sync_cand   = {hunt_sr_q[6:0], bus.bit_in};

  ask_bit_deser u_deser (
    .clk       (clk),
    .rst       (rst),
    .clr       (deser_clr),
    .shift     (deser_shift),
    .bit_in    (bus.bit_in),
    .byte_next (byte_next),
    .byte_done (byte_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hunt_sr_d     = hunt_sr_q;
    idx_d         = idx_q;
    ck_d          = ck_q;
    timer_d       = timer_q;
    byte_out_d    = byte_out_q;
    byte_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_ok_d    = frame_ok_q;
    frame_cnt_d   = frame_cnt_q;
    err_cnt_d     = err_cnt_q;
    deser_clr     = 1'b0;

    if (!bus.en) begin
      // Silent return to HUNT: no frame_done, counters untouched.
      state_d   = HUNT;
      hunt_sr_d = '0;
      timer_d   = '0;
      deser_clr = 1'b1;
    end else begin
      unique case (state_q)
        HUNT: begin
          timer_d = '0;
          if (acc) begin
            hunt_sr_d = sync_cand;
            if (sync_cand == SYNC_WORD) begin
              state_d       = PAYLOAD;
              frame_start_d = 1'b1;
              idx_d         = '0;
              ck_d          = '0;
              deser_clr     = 1'b1;
            end
          end
        end

        PAYLOAD, CHECK: begin
          // Held clear while locked so the hunt restarts from zeros afterwards.
          hunt_sr_d = '0;
          if (acc) begin
            timer_d = '0;
          end else if (timer_q == TIM_W'(TIMEOUT_CYC - 1)) begin
            state_d      = HUNT;
            timer_d      = '0;
            deser_clr    = 1'b1;
            frame_done_d = 1'b1;
            frame_ok_d   = 1'b0;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            timer_d = timer_q + 1'b1;
          end

          if (byte_done) begin
            if (state_q == PAYLOAD) begin
              byte_out_d   = byte_next;
              byte_valid_d = 1'b1;
              ck_d         = ck_q ^ byte_next;
              idx_d        = idx_q + 1'b1;
              if (idx_q == IDX_W'(PAYLOAD_LEN - 1)) state_d = CHECK;
            end else begin
              state_d      = HUNT;
              frame_done_d = 1'b1;
              frame_ok_d   = (byte_next == ck_q);
              if (byte_next == ck_q) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
              end else if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
              end
            end
          end
        end

        default: state_d = HUNT;
      endcase
    end

    sync_lock_d = (state_d != HUNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hunt_sr_q     <= '0;
      idx_q         <= '0;
      ck_q          <= '0;
      timer_q       <= '0;
      byte_out_q    <= '0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_ok_q    <= 1'b0;
      sync_lock_q   <= 1'b0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      hunt_sr_q     <= hunt_sr_d;
      idx_q         <= idx_d;
      ck_q          <= ck_d;
      timer_q       <= timer_d;
      byte_out_q    <= byte_out_d;
      byte_valid_q  <= byte_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_ok_q    <= frame_ok_d;
      sync_lock_q   <= sync_lock_d;
      frame_cnt_q   <= frame_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign bus.byte_out    = byte_out_q;
  assign bus.byte_valid  = byte_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_ok    = frame_ok_q;
  assign bus.sync_lock   = sync_lock_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_ask_frame_sync.sv
// tb/tb_ask_frame_sync.sv - scoreboard bench for ask_frame_sync
module tb_ask_frame_sync;

  localparam int K_START = 0;
  localparam int K_BYTE  = 1;
  localparam int K_DONE  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       ok;
    logic [7:0] fc;
    logic [7:0] ec;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ev_t  exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic [7:0] m_fc = 8'd0;
  logic [7:0] m_ec = 8'd0;

  ask_frame_sync_if bus ();

  ask_frame_sync #(
    .SYNC_WORD   (8'hA5),
    .PAYLOAD_LEN (4),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic take(input int kind, input logic [7:0] data, input logic ok,
                      input logic [7:0] fc, input logic [7:0] ec);
    ev_t e;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind=%0d data=%h ok=%b fc=%0d ec=%0d, expected none",
               kind, data, ok, fc, ec);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind ||
          (kind == K_BYTE && e.data !== data) ||
          (kind == K_DONE && (e.ok !== ok || e.fc !== fc || e.ec !== ec)))
        $display("FAIL event: got kind=%0d data=%h ok=%b fc=%0d ec=%0d, expected kind=%0d data=%h ok=%b fc=%0d ec=%0d",
                 kind, data, ok, fc, ec, e.kind, e.data, e.ok, e.fc, e.ec);
      else
        n_pass++;
    end
  endtask

  // Monitor: compares every DUT output event against the scoreboard queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_start) take(K_START, 8'h00, 1'b0, 8'h00, 8'h00);
      if (bus.byte_valid)  take(K_BYTE, bus.byte_out, 1'b0, 8'h00, 8'h00);
      if (bus.frame_done)  take(K_DONE, 8'h00, bus.frame_ok, bus.frame_cnt, bus.err_cnt);
    end
  end

  task automatic push(input int kind, input logic [7:0] data, input logic ok);
    ev_t e;
    e.kind = kind; e.data = data; e.ok = ok;
    if (kind == K_DONE) begin
      if (ok) m_fc = m_fc + 8'd1;
      else if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
    end
    e.fc = m_fc; e.ec = m_ec;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    @(negedge clk);
    bus.bit_valid = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_frame(input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3,
                            input logic [7:0] ck, input logic ok);
    logic [7:0] p [4];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    push(K_START, 8'h00, 1'b0);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) begin
      push(K_BYTE, p[i], 1'b0);
      send_byte(p[i]);
    end
    push(K_DONE, 8'h00, ok);
    send_byte(ck);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, exp_q.size(), 0);
    repeat (10) @(negedge clk);
  endtask

  task automatic chk_idle(input string tag, input logic [7:0] fc, input logic [7:0] ec);
    chk({tag, "_byte_out"},    bus.byte_out, 0);
    chk({tag, "_byte_valid"},  bus.byte_valid, 0);
    chk({tag, "_frame_start"}, bus.frame_start, 0);
    chk({tag, "_frame_done"},  bus.frame_done, 0);
    chk({tag, "_frame_ok"},    bus.frame_ok, 0);
    chk({tag, "_sync_lock"},   bus.sync_lock, 0);
    chk({tag, "_frame_cnt"},   bus.frame_cnt, fc);
    chk({tag, "_err_cnt"},     bus.err_cnt, ec);
  endtask

  initial begin
    bus.en        = 1'b1;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset", 8'd0, 8'd0);
    rst = 1'b0;

    // 1: asynchronous reset in the middle of a payload
    push(K_START, 8'h00, 1'b0);
    send_byte(8'hA5);
    push(K_BYTE, 8'h11, 1'b0);
    send_byte(8'h11);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("t1_lock_before_rst", bus.sync_lock, 1);
    wait_drain("t1_drain", 20);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_idle("t1_async_rst", 8'd0, 8'd0);
    exp_q.delete();
    m_fc = 8'd0;
    m_ec = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk_idle("t1_idle", 8'd0, 8'd0);

    // 2: good frame, ck = 11^22^33^44 = 44
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 1'b1);
    wait_drain("t2_drain", 40);
    chk("t2_unlocked", bus.sync_lock, 0);

    // 3: same frame, wrong checksum
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h45, 1'b0);
    wait_drain("t3_drain", 40);

    // 4: near-miss patterns before the real sync; ck = 5A^C3^0F^F0 = 66
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_byte(8'hA4);
    send_bit(1'b1); send_bit(1'b0);
    chk("t4_no_early_lock", bus.sync_lock, 0);
    send_frame(8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h66, 1'b1);
    wait_drain("t4_drain", 40);

    // 5: timeout after 12 payload bits, then a good frame (ck = 01^02^04^08 = 0F)
    push(K_START, 8'h00, 1'b0);
    send_byte(8'hA5);
    push(K_BYTE, 8'h11, 1'b0);
    send_byte(8'h11);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    chk("t5_locked_before_timeout", bus.sync_lock, 1);
    push(K_DONE, 8'h00, 1'b0);
    wait_drain("t5_timeout_drain", 200);
    chk("t5_unlocked", bus.sync_lock, 0);
    send_frame(8'h01, 8'h02, 8'h04, 8'h08, 8'h0F, 1'b1);
    wait_drain("t5_drain", 40);

    // 6: en low for one clock mid-payload, with a bit offered during it
    push(K_START, 8'h00, 1'b0);
    send_byte(8'hA5);
    push(K_BYTE, 8'hAA, 1'b0);
    send_byte(8'hAA);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(negedge clk);
    bus.en        = 1'b0;
    bus.bit_in    = 1'b1;
    bus.bit_valid = 1'b1;
    @(negedge clk);
    bus.en        = 1'b1;
    bus.bit_valid = 1'b0;
    chk("t6_unlocked", bus.sync_lock, 0);
    repeat (100) @(negedge clk);
    chk("t6_frame_cnt_hold", bus.frame_cnt, m_fc);
    chk("t6_err_cnt_hold", bus.err_cnt, m_ec);
    wait_drain("t6_quiet", 5);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 1'b1);
    wait_drain("t6_drain", 40);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
